// File: rtl/pixl_a8_pkg.sv
// rtl/pixl_a8_pkg.sv - shared types and constants for the Atari 8-bit bus sequencer
// Holds the sequencer state encoding, the register window pages and the
// default bus timing (all timing values are in system clk cycles).
package pixl_a8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR_WAIT,
    RD_REQ,
    DRIVE,
    SKIP
  } a8_state_t;

  localparam logic [7:0] PAGE_PBI  = 8'hD1;
  localparam logic [7:0] PAGE_CART = 8'hD5;

  localparam int ADDR_SETTLE_DEF = 6;
  localparam int DATA_SAMPLE_DEF = 18;
  localparam int RD_TIMEOUT_DEF  = 10;
  localparam int OE_HOLD_DEF     = 2;

  localparam logic [5:0] CNT_MAX = 6'd63;

endpackage

// File: rtl/a8_phi2_sync.sv
// rtl/a8_phi2_sync.sv - synchronisers for the Atari control pins plus phi2 edge pulses
// Ports:
//   clk, rst          system clock, async active-high reset
//   a8_clk            phi2 pin (async)
//   a8_rst_n          Atari reset pin (async)
//   a8_rw_n, a8_ref_n rw and refresh pins (async)
//   rst_n_sync, rw_n_sync, ref_n_sync  2-flop synchronised copies
//   rise, fall        1-clk pulses on synchronised phi2 edges
module a8_phi2_sync (
  input  logic clk,
  input  logic rst,
  input  logic a8_clk,
  input  logic a8_rst_n,
  input  logic a8_rw_n,
  input  logic a8_ref_n,
  output logic rst_n_sync,
  output logic rw_n_sync,
  output logic ref_n_sync,
  output logic rise,
  output logic fall
);

  // Bit order {ref_n, rw_n, rst_n, phi2}; idle values: no refresh, read,
  // Atari held in reset, phi2 low.
  localparam logic [3:0] SYNC_RST = 4'b1100;

  logic [3:0] meta;
  logic [3:0] sync;
  logic       phi2_d;
  logic [2:0] vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= SYNC_RST;
      sync   <= SYNC_RST;
      phi2_d <= 1'b0;
      vld    <= 3'b000;
    end else begin
      meta   <= {a8_ref_n, a8_rw_n, a8_rst_n, a8_clk};
      sync   <= meta;
      phi2_d <= sync[0];
      vld    <= {vld[1:0], 1'b1};
    end
  end

  // Edges are only reported once phi2_d holds a real pin sample, so a
  // reset release while phi2 is high does not fake a cycle start.
  assign rise       = vld[2] &  sync[0] & ~phi2_d;
  assign fall       = vld[2] & ~sync[0] &  phi2_d;
  assign rst_n_sync = sync[1];
  assign rw_n_sync  = sync[2];
  assign ref_n_sync = sync[3];

endmodule

// File: rtl/a8_bus_sequencer.sv
// rtl/a8_bus_sequencer.sv - Atari 8-bit cartridge/PBI bus cycle sequencer
// Ports:
//   clk, rst                       system clock, async active-high reset
//   a8_clk, a8_rst_n, a8_addr,
//   a8_data_in, a8_rw_n, a8_ref_n  Atari bus inputs (async to clk)
//   a8_data_out, a8_data_oe        read data and bus driver enable
//   a8_mpd_n, mpd_en               math-pack disable and its control bit
//   reg_addr, reg_wr, reg_wdata,
//   reg_rd, reg_rdata, reg_rd_ack  register file access
//   err, err_clr                   sticky timeout/deadline error and clear
module a8_bus_sequencer
  import pixl_a8_pkg::*;
#(
  parameter logic [7:0] WIN_PAGE    = PAGE_PBI,
  parameter int         ADDR_SETTLE = ADDR_SETTLE_DEF,
  parameter int         DATA_SAMPLE = DATA_SAMPLE_DEF,
  parameter int         RD_TIMEOUT  = RD_TIMEOUT_DEF,
  parameter int         OE_HOLD     = OE_HOLD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a8_clk,
  input  logic        a8_rst_n,
  input  logic [15:0] a8_addr,
  input  logic [7:0]  a8_data_in,
  input  logic        a8_rw_n,
  input  logic        a8_ref_n,
  output logic [7:0]  a8_data_out,
  output logic        a8_data_oe,
  output logic        a8_mpd_n,
  input  logic        mpd_en,
  output logic [7:0]  reg_addr,
  output logic        reg_wr,
  output logic [7:0]  reg_wdata,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  input  logic        reg_rd_ack,
  output logic        err,
  input  logic        err_clr
);

  logic rst_n_sync, rw_n_sync, ref_n_sync, rise, fall;

  a8_phi2_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .a8_clk     (a8_clk),
    .a8_rst_n   (a8_rst_n),
    .a8_rw_n    (a8_rw_n),
    .a8_ref_n   (a8_ref_n),
    .rst_n_sync (rst_n_sync),
    .rw_n_sync  (rw_n_sync),
    .ref_n_sync (ref_n_sync),
    .rise       (rise),
    .fall       (fall)
  );

  a8_state_t  state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [7:0] rd_cnt, rd_cnt_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       holding, holding_nxt;
  logic [7:0] dout_nxt, addr_nxt, wdata_nxt;
  logic       oe_nxt, wr_nxt, rd_nxt, err_set, err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_cnt      <= '0;
      hold_cnt    <= '0;
      holding     <= 1'b0;
      a8_data_out <= 8'h00;
      a8_data_oe  <= 1'b0;
      a8_mpd_n    <= 1'b1;
      reg_addr    <= 8'h00;
      reg_wr      <= 1'b0;
      reg_wdata   <= 8'h00;
      reg_rd      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rd_cnt      <= rd_cnt_nxt;
      hold_cnt    <= hold_nxt;
      holding     <= holding_nxt;
      a8_data_out <= dout_nxt;
      a8_data_oe  <= oe_nxt;
      a8_mpd_n    <= ~(mpd_en & rst_n_sync);
      reg_addr    <= addr_nxt;
      reg_wr      <= wr_nxt;
      reg_wdata   <= wdata_nxt;
      reg_rd      <= rd_nxt;
      err         <= err_nxt;
    end
  end

  // Counted actions compare against N-1 so the registered strobe or
  // sample lands on the edge where cnt itself becomes N.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rd_cnt_nxt  = (rd_cnt != 8'hFF) ? rd_cnt + 8'd1 : rd_cnt;
    hold_nxt    = hold_cnt;
    holding_nxt = holding;
    dout_nxt    = a8_data_out;
    oe_nxt      = a8_data_oe;
    addr_nxt    = reg_addr;
    wdata_nxt   = reg_wdata;
    wr_nxt      = 1'b0;
    rd_nxt      = 1'b0;
    err_set     = 1'b0;

    if (rise) begin
      cnt_nxt = '0;
    end else if (state != IDLE && cnt != CNT_MAX) begin
      cnt_nxt = cnt + 6'd1;
    end

    if (!rst_n_sync) begin
      state_nxt   = IDLE;
      oe_nxt      = 1'b0;
      holding_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) state_nxt = ADDR;
        end
        ADDR: begin
          if (fall) begin
            state_nxt = IDLE;
            err_set   = 1'b1;
          end else if (cnt == 6'(ADDR_SETTLE - 1)) begin
            addr_nxt = a8_addr[7:0];
            if (a8_addr[15:8] != WIN_PAGE || !ref_n_sync) begin
              state_nxt = SKIP;
            end else if (!rw_n_sync) begin
              state_nxt = WR_WAIT;
            end else begin
              state_nxt  = RD_REQ;
              rd_nxt     = 1'b1;
              rd_cnt_nxt = '0;
            end
          end
        end
        WR_WAIT: begin
          if (fall) begin
            state_nxt = IDLE;
            err_set   = 1'b1;
          end else if (cnt == 6'(DATA_SAMPLE - 1)) begin
            wdata_nxt = a8_data_in;
            wr_nxt    = 1'b1;
            state_nxt = SKIP;
          end
        end
        RD_REQ: begin
          if (fall) begin
            state_nxt = IDLE;
            err_set   = 1'b1;
          end else if (reg_rd_ack) begin
            dout_nxt  = reg_rdata;
            oe_nxt    = 1'b1;
            state_nxt = DRIVE;
          end else if (rd_cnt == 8'(RD_TIMEOUT - 1)) begin
            dout_nxt  = 8'hFF;
            oe_nxt    = 1'b1;
            err_set   = 1'b1;
            state_nxt = DRIVE;
          end
        end
        DRIVE: begin
          if (rise) begin
            // New cycle started while still driving: release the bus now.
            oe_nxt      = 1'b0;
            holding_nxt = 1'b0;
            err_set     = 1'b1;
            state_nxt   = ADDR;
          end else if (holding) begin
            if (hold_cnt <= 4'd1) begin
              oe_nxt      = 1'b0;
              holding_nxt = 1'b0;
              state_nxt   = IDLE;
            end else begin
              hold_nxt = hold_cnt - 4'd1;
            end
          end else if (fall) begin
            if (OE_HOLD <= 1) begin
              oe_nxt    = 1'b0;
              state_nxt = IDLE;
            end else begin
              holding_nxt = 1'b1;
              hold_nxt    = 4'(OE_HOLD - 1);
            end
          end
        end
        SKIP: begin
          if (fall) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    err_nxt = err_set | (err & ~err_clr);
  end

endmodule

// File: tb/tb_a8_bus_sequencer.sv
// tb/tb_a8_bus_sequencer.sv - scoreboard bench for the Atari bus sequencer
`timescale 1ns/1ps
module tb_a8_bus_sequencer;

  localparam int PHI_HI = 28;
  localparam int PHI_LO = 28;

  logic        clk = 1'b0;
  logic        rst;
  logic        a8_clk, a8_rst_n, a8_rw_n, a8_ref_n;
  logic [15:0] a8_addr;
  logic [7:0]  a8_data_in, a8_data_out, reg_addr, reg_wdata, reg_rdata;
  logic        a8_data_oe, a8_mpd_n, mpd_en, reg_wr, reg_rd, reg_rd_ack, err, err_clr;

  a8_bus_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .a8_clk      (a8_clk),
    .a8_rst_n    (a8_rst_n),
    .a8_addr     (a8_addr),
    .a8_data_in  (a8_data_in),
    .a8_rw_n     (a8_rw_n),
    .a8_ref_n    (a8_ref_n),
    .a8_data_out (a8_data_out),
    .a8_data_oe  (a8_data_oe),
    .a8_mpd_n    (a8_mpd_n),
    .mpd_en      (mpd_en),
    .reg_addr    (reg_addr),
    .reg_wr      (reg_wr),
    .reg_wdata   (reg_wdata),
    .reg_rd      (reg_rd),
    .reg_rdata   (reg_rdata),
    .reg_rd_ack  (reg_rd_ack),
    .err         (err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 = write strobe, 1 = read data driven
    int addr;
    int data;
    int lat;    // write: clks from pin rise; read: clks from reg_rd to oe
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_wr = 0;
  int   exp_rd = 0;
  int   cnt_wr, cnt_rd;
  logic ack_mode = 1'b1;
  logic [7:0] ack_data = 8'h00;
  logic exp_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_cycle(input logic [15:0] addr, input logic rw_n, input logic [7:0] wd,
                           input logic ref_n, input int hi);
    @(negedge clk);
    a8_addr    = addr;
    a8_rw_n    = rw_n;
    a8_data_in = wd;
    a8_ref_n   = ref_n;
    a8_clk     = 1'b1;
    repeat (hi) @(negedge clk);
    a8_clk = 1'b0;
    repeat (PHI_LO) @(negedge clk);
    a8_ref_n = 1'b1;
  endtask

  task automatic push(input int kind, input int addr, input int data, input int lat);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Register file responder: ack 3 clk after a read request when enabled.
  initial begin
    reg_rd_ack = 1'b0;
    reg_rdata  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (reg_rd && ack_mode) begin
        repeat (3) @(posedge clk);
        #1;
        reg_rdata  = ack_data;
        reg_rd_ack = 1'b1;
        @(posedge clk); #1;
        reg_rd_ack = 1'b0;
      end
    end
  end

  // Output monitor: pops the scoreboard on each write strobe and each oe rise.
  initial begin
    logic prev_pin, prev_oe;
    int   since_rise, since_fall, since_rd;
    exp_t e;
    prev_pin = 1'b0; prev_oe = 1'b0;
    since_rise = 0; since_fall = 0; since_rd = 0;
    cnt_wr = 0; cnt_rd = 0;
    forever begin
      @(posedge clk); #1;
      if (a8_clk && !prev_pin) since_rise = 1; else since_rise++;
      if (!a8_clk && prev_pin) since_fall = 1; else since_fall++;
      prev_pin = a8_clk;
      since_rd++;
      if (reg_rd) begin
        since_rd = 0;
        cnt_rd++;
      end
      if (reg_wr && reg_rd) chk("wr_rd_exclusive", 1, 0);
      if (reg_wr) begin
        cnt_wr++;
        if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_event_kind", 0, e.kind);
          chk("wr_addr", reg_addr, e.addr);
          chk("wr_data", reg_wdata, e.data);
          chk("wr_latency", since_rise, e.lat);
        end
      end
      if (a8_data_oe && !prev_oe) begin
        if (exp_q.size() == 0) chk("unexpected_oe", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rd_event_kind", 1, e.kind);
          chk("rd_addr", reg_addr, e.addr);
          chk("rd_data", a8_data_out, e.data);
          chk("rd_latency", since_rd, e.lat);
        end
      end
      prev_oe = a8_data_oe;
      if (exp_hold && since_fall == 3) chk("oe_hold", a8_data_oe, 1);
      if (exp_hold && since_fall == 4) chk("oe_release", a8_data_oe, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; a8_clk = 1'b0; a8_rst_n = 1'b1; a8_rw_n = 1'b1; a8_ref_n = 1'b1;
    a8_addr = 16'h0000; a8_data_in = 8'h00; mpd_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", a8_data_out, 8'h00);
    chk("rst_oe", a8_data_oe, 0);
    chk("rst_mpd_n", a8_mpd_n, 1);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_reg_wdata", reg_wdata, 8'h00);
    chk("rst_reg_rd", reg_rd, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Write $5A to $D123.
    push(0, 8'h23, 8'h5A, 21); exp_wr++;
    bus_cycle(16'hD123, 1'b0, 8'h5A, 1'b1, PHI_HI);
    chk("wr_err", err, 0);

    // Read $D1F0, acked with $C3.
    ack_mode = 1'b1; ack_data = 8'hC3; exp_hold = 1'b1;
    push(1, 8'hF0, 8'hC3, 4); exp_rd++;
    bus_cycle(16'hD1F0, 1'b1, 8'h00, 1'b1, PHI_HI);
    exp_hold = 1'b0;
    chk("rd_err", err, 0);

    // Read $D100 with no ack: timeout drives $FF and sets err.
    ack_mode = 1'b0; exp_hold = 1'b1;
    push(1, 8'h00, 8'hFF, 10); exp_rd++;
    bus_cycle(16'hD100, 1'b1, 8'h00, 1'b1, PHI_HI);
    exp_hold = 1'b0;
    chk("timeout_err", err, 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    chk("err_cleared", err, 0);
    ack_mode = 1'b1;

    // Unselected cycles: other page, refresh, Atari reset held.
    bus_cycle(16'hD500, 1'b1, 8'h00, 1'b1, PHI_HI);
    bus_cycle(16'hD144, 1'b1, 8'h00, 1'b0, PHI_HI);
    mpd_en = 1'b1; a8_rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("mpd_n_in_a8_reset", a8_mpd_n, 1);
    bus_cycle(16'hD155, 1'b0, 8'h77, 1'b1, PHI_HI);
    a8_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mpd_n_enabled", a8_mpd_n, 0);
    chk("unselected_err", err, 0);

    // Short phi2 on a write: aborted, no strobe, err set.
    bus_cycle(16'hD140, 1'b0, 8'h11, 1'b1, 12);
    chk("short_err", err, 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    chk("short_err_cleared", err, 0);
    ack_data = 8'h3C; exp_hold = 1'b1;
    push(1, 8'hAA, 8'h3C, 4); exp_rd++;
    bus_cycle(16'hD1AA, 1'b1, 8'h00, 1'b1, PHI_HI);
    exp_hold = 1'b0;

    // Async reset while driving the bus.
    ack_data = 8'h96;
    push(1, 8'hF0, 8'h96, 4); exp_rd++;
    @(negedge clk);
    a8_addr = 16'hD1F0; a8_rw_n = 1'b1; a8_clk = 1'b1;
    for (int i = 0; i < 60 && !a8_data_oe; i++) @(negedge clk);
    chk("pre_rst_oe_seen", a8_data_oe, 1);
    @(posedge clk); #7;
    rst = 1'b1;
    #1;
    chk("async_oe", a8_data_oe, 0);
    chk("async_data_out", a8_data_out, 8'h00);
    chk("async_reg_addr", reg_addr, 8'h00);
    chk("async_mpd_n", a8_mpd_n, 1);
    chk("async_err", err, 0);
    chk("async_strobes", {reg_wr, reg_rd}, 2'b00);
    @(negedge clk);
    a8_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (PHI_LO) @(negedge clk);

    ack_data = 8'hC3; exp_hold = 1'b1;
    push(1, 8'hF0, 8'hC3, 4); exp_rd++;
    bus_cycle(16'hD1F0, 1'b1, 8'h00, 1'b1, PHI_HI);
    exp_hold = 1'b0;
    chk("post_rst_err", err, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("total_reg_wr", cnt_wr, exp_wr);
    chk("total_reg_rd", cnt_rd, exp_rd);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/a8_bus_sequencer.md
Name: a8_bus_sequencer

Overview:
- Sequences every Atari 8-bit bus cycle on the cartridge/PBI connector, running on the FPGA system clock with phi2 (a8_clk) sampled as data.
- Detects phi2 edges, qualifies the cycle (not refresh, not in reset), and decodes a one-page register window.
- Issues single-cycle read/write strobes to the internal register file, and drives read data and output-enable back onto a8_data within the phi2-high window.
- Owns a8_mpd_n.

Parameters:
- WIN_PAGE, 8'hD1: a8_addr[15:8] value selecting the register window.
- ADDR_SETTLE, 6: clk cycles after detected phi2 rise before address/rw are sampled.
- DATA_SAMPLE, 18: clk cycles after detected phi2 rise at which write data is captured.
- RD_TIMEOUT, 10: max clk cycles from reg_rd to reg_rd_ack.
- OE_HOLD, 2: clk cycles a8_data_oe stays high after detected phi2 fall.

Ports:
- clk  in  1  system clock (>=64 MHz).
- rst  in  1  asynchronous active-high reset.
- a8_clk  in  1  Atari phi2, asynchronous to clk.
- a8_rst_n  in  1  Atari reset, asynchronous.
- a8_addr  in  16  Atari address bus.
- a8_data_in  in  8  Atari data bus, input side.
- a8_rw_n  in  1  1 = read, 0 = write.
- a8_ref_n  in  1  0 = refresh cycle.
- a8_data_out  out  8  read data to bus.
- a8_data_oe  out  1  bus driver enable.
- a8_mpd_n  out  1  math-pack disable, active-low.
- mpd_en  in  1  control bit from the register file.
- reg_addr  out  8  register offset (a8_addr[7:0]).
- reg_wr  out  1  one-clk write strobe.
- reg_wdata  out  8  write data.
- reg_rd  out  1  one-clk read request.
- reg_rdata  in  8  read data.
- reg_rd_ack  in  1  read data valid.
- err  out  1  sticky: read timeout or missed deadline.
- err_clr  in  1  clears err.

Behaviour:
- Reset values: a8_data_out=8'h00, a8_data_oe=0, a8_mpd_n=1, reg_addr=0, reg_wr=0, reg_wdata=0, reg_rd=0, err=0, state=IDLE.
- Reset is async: oe drops the same instant rst rises.
- Synchronisation: a8_clk, a8_rst_n, a8_rw_n and a8_ref_n each pass through a 2-flop synchroniser; edge detect on the synced phi2 (rise/fall pulses are 1 clk, 3 clk after the pin edge).
- a8_addr and a8_data_in are sampled raw at the counted points.
- a8_mpd_n is a registered copy of ~(mpd_en & a8_rst_n_sync): 1-clk latency, forced to 1 while a8_rst_n_sync=0.
- Cycle counter `cnt` is 6 bits: cleared on phi2 rise, increments while state!=IDLE, saturates at 63.
- FSM:
  - IDLE: on rise -> ADDR.
  - ADDR: at cnt==ADDR_SETTLE, latch addr/rw.
    - Selected = addr[15:8]==WIN_PAGE & ref_n_sync & a8_rst_n_sync.
    - Not selected -> SKIP.
    - rw=0 -> WR_WAIT.
    - rw=1 -> RD_REQ: reg_rd pulses 1 clk with reg_addr=addr[7:0].
  - WR_WAIT: at cnt==DATA_SAMPLE, latch reg_wdata, pulse reg_wr 1 clk -> SKIP.
  - RD_REQ:
    - On reg_rd_ack: latch reg_rdata into a8_data_out, oe=1 -> DRIVE.
    - If RD_TIMEOUT cycles elapse without ack: a8_data_out=8'hFF, oe=1, err=1 -> DRIVE.
  - DRIVE: on fall, load hold counter; oe=0 after OE_HOLD clks -> IDLE.
  - SKIP: on fall -> IDLE.
- Premature fall (in ADDR, WR_WAIT or RD_REQ):
  - Abort -> IDLE, no reg_wr issued, err=1.
  - oe never asserted for that cycle.
  - A late reg_rd_ack after abort is ignored.
- Rise while in DRIVE hold is a protocol violation: oe=0 immediately, err=1, treat as new cycle -> ADDR.
- a8_rst_n_sync low in any state: -> IDLE next clk, oe=0, no strobes issued; err unaffected.
- err_clr has priority below a same-cycle err set (set wins).
- At most one reg_wr or reg_rd per phi2 cycle.
- reg_wr and reg_rd are never asserted together.

Decomposition:
- Shared package pixl_a8_pkg holds:
  - state enum (IDLE, ADDR, WR_WAIT, RD_REQ, DRIVE, SKIP);
  - PAGE_PBI=8'hD1 and PAGE_CART=8'hD5;
  - default timing constants.
- One sub-module: a8_phi2_sync (2-flop synchronisers for phi2/rst_n/rw_n/ref_n plus rise/fall pulse generation, async active-high reset).

Test Plan:
- Write: phi2 at 1.79 MHz, clk 100 MHz; write 8'h5A to $D123 -> exactly one reg_wr, reg_addr=8'h23, reg_wdata=8'h5A, issued 21 clk after phi2 pin rise. No oe.
- Read: read $D1F0, reg_rd_ack 3 clk after reg_rd with reg_rdata=8'hC3 -> a8_data_out=8'hC3, oe high until 2 clk after detected fall. err=0.
- Read timeout: read $D100 with no ack -> a8_data_out=8'hFF, oe asserted 10 clk after reg_rd, err=1. err_clr -> err=0.
- Not selected: cycles to $D500, $D1xx with ref_n=0, and $D1xx with a8_rst_n=0 -> no reg_rd/reg_wr, oe stays 0. mpd_en=1 with a8_rst_n=0 -> a8_mpd_n=1; after a8_rst_n release -> 0.
- Short phi2: high time of 12 clk on a write -> no reg_wr, err=1, FSM back in IDLE before next rise.
- Async reset mid-DRIVE: assert rst while oe=1 -> oe=0 with no clk edge, all outputs at reset values. Next valid read is served normally.
